// File: rtl/axi_master_arbiter_if.sv
// Bundle between the IFU/LSU requesters, the arbiter and the AXI4 slave.
// master modport is the arbiter's view; slave modport is the environment's view.
interface axi_master_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              ifu_req_valid;
   logic              ifu_req_ready;
   logic [ADDR_W-1:0] ifu_addr;
   logic              ifu_resp_valid;
   logic [DATA_W-1:0] ifu_rdata;
   logic              ifu_resp_err;

   logic              lsu_req_valid;
   logic              lsu_req_ready;
   logic              lsu_wen;
   logic [ADDR_W-1:0] lsu_addr;
   logic [2:0]        lsu_size;
   logic [DATA_W-1:0] lsu_wdata;
   logic [3:0]        lsu_wstrb;
   logic              lsu_resp_valid;
   logic [DATA_W-1:0] lsu_rdata;
   logic              lsu_resp_err;

   logic              io_master_awvalid;
   logic              io_master_awready;
   logic [ADDR_W-1:0] io_master_awaddr;
   logic [3:0]        io_master_awid;
   logic [7:0]        io_master_awlen;
   logic [2:0]        io_master_awsize;
   logic [1:0]        io_master_awburst;
   logic              io_master_wvalid;
   logic              io_master_wready;
   logic [DATA_W-1:0] io_master_wdata;
   logic [3:0]        io_master_wstrb;
   logic              io_master_wlast;
   logic              io_master_bvalid;
   logic              io_master_bready;
   logic [1:0]        io_master_bresp;
   logic [3:0]        io_master_bid;
   logic              io_master_arvalid;
   logic              io_master_arready;
   logic [ADDR_W-1:0] io_master_araddr;
   logic [3:0]        io_master_arid;
   logic [7:0]        io_master_arlen;
   logic [2:0]        io_master_arsize;
   logic [1:0]        io_master_arburst;
   logic              io_master_rvalid;
   logic              io_master_rready;
   logic [1:0]        io_master_rresp;
   logic [DATA_W-1:0] io_master_rdata;
   logic              io_master_rlast;
   logic [3:0]        io_master_rid;

   modport master (
      input  ifu_req_valid, ifu_addr,
      output ifu_req_ready, ifu_resp_valid, ifu_rdata, ifu_resp_err,
      input  lsu_req_valid, lsu_wen, lsu_addr, lsu_size, lsu_wdata, lsu_wstrb,
      output lsu_req_ready, lsu_resp_valid, lsu_rdata, lsu_resp_err,
      output io_master_awvalid, io_master_awaddr, io_master_awid,
      output io_master_awlen, io_master_awsize, io_master_awburst,
      input  io_master_awready,
      output io_master_wvalid, io_master_wdata, io_master_wstrb, io_master_wlast,
      input  io_master_wready,
      input  io_master_bvalid, io_master_bresp, io_master_bid,
      output io_master_bready,
      output io_master_arvalid, io_master_araddr, io_master_arid,
      output io_master_arlen, io_master_arsize, io_master_arburst,
      input  io_master_arready,
      input  io_master_rvalid, io_master_rresp, io_master_rdata,
      input  io_master_rlast, io_master_rid,
      output io_master_rready
   );

   modport slave (
      output ifu_req_valid, ifu_addr,
      input  ifu_req_ready, ifu_resp_valid, ifu_rdata, ifu_resp_err,
      output lsu_req_valid, lsu_wen, lsu_addr, lsu_size, lsu_wdata, lsu_wstrb,
      input  lsu_req_ready, lsu_resp_valid, lsu_rdata, lsu_resp_err,
      input  io_master_awvalid, io_master_awaddr, io_master_awid,
      input  io_master_awlen, io_master_awsize, io_master_awburst,
      output io_master_awready,
      input  io_master_wvalid, io_master_wdata, io_master_wstrb, io_master_wlast,
      output io_master_wready,
      output io_master_bvalid, io_master_bresp, io_master_bid,
      input  io_master_bready,
      input  io_master_arvalid, io_master_araddr, io_master_arid,
      input  io_master_arlen, io_master_arsize, io_master_arburst,
      output io_master_arready,
      output io_master_rvalid, io_master_rresp, io_master_rdata,
      output io_master_rlast, io_master_rid,
      input  io_master_rready
   );
endinterface

// File: rtl/axi_master_arbiter.sv
// Shares one single-beat AXI4 master port between IFU (read) and LSU (r/w).
// Define YSYX_ARB_RR_EN for round-robin grant instead of fixed LSU priority.
module axi_master_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                 clock,
   input  logic                 reset,
   axi_master_arbiter_if.master bus
);

   typedef enum logic [2:0] {
      IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, RESP
   } state_t;

   localparam logic OWN_IFU = 1'b0;
   localparam logic OWN_LSU = 1'b1;

   state_t            state;
   state_t            state_nx;
   logic              owner;
   logic [ADDR_W-1:0] addr_q;
   logic [2:0]        size_q;
   logic [1:0]        sh_q;
   logic [DATA_W-1:0] wdata_q;
   logic [3:0]        wstrb_q;
   logic              aw_done;
   logic              w_done;
   logic [DATA_W-1:0] data_q;
   logic              err_q;

   logic idle;
   logic lsu_first;
   logic grant_ifu;
   logic grant_lsu;
   logic arvalid;
   logic rready;
   logic awvalid;
   logic wvalid;
   logic bready;
   logic ifu_resp;
   logic lsu_resp;

   logic unused_in;
   assign unused_in = ^{bus.io_master_bid, bus.io_master_rid,
                        bus.io_master_rlast, bus.io_master_rresp[0],
                        bus.io_master_bresp[0]};

`ifdef YSYX_ARB_RR_EN
   logic last_owner;

   // Remember who was served last so the other side wins the next conflict.
   always_ff @(posedge clock or posedge reset) begin
      if (reset)          last_owner <= OWN_IFU;
      else if (grant_lsu) last_owner <= OWN_LSU;
      else if (grant_ifu) last_owner <= OWN_IFU;
   end

   assign lsu_first = (last_owner == OWN_IFU);
`else
   assign lsu_first = 1'b1;
`endif

   // Grant at most one requester, only while idle and out of reset.
   always_comb begin
      idle      = (state == IDLE) && !reset;
      grant_lsu = idle && bus.lsu_req_valid &&
                  (lsu_first || !bus.ifu_req_valid);
      grant_ifu = idle && bus.ifu_req_valid && !grant_lsu;
   end

   // State register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   // Next state and handshake strobes.
   always_comb begin
      state_nx = state;
      arvalid  = 1'b0;
      rready   = 1'b0;
      awvalid  = 1'b0;
      wvalid   = 1'b0;
      bready   = 1'b0;
      ifu_resp = 1'b0;
      lsu_resp = 1'b0;
      unique case (state)
         IDLE: begin
            if (grant_lsu)
               state_nx = bus.lsu_wen ? WR_REQ : RD_ADDR;
            else if (grant_ifu)
               state_nx = RD_ADDR;
         end
         RD_ADDR: begin
            arvalid = 1'b1;
            if (bus.io_master_arready) state_nx = RD_DATA;
         end
         RD_DATA: begin
            rready = 1'b1;
            if (bus.io_master_rvalid) state_nx = RESP;
         end
         WR_REQ: begin
            awvalid = !aw_done;
            wvalid  = !w_done;
            if (aw_done && w_done) state_nx = WR_RESP;
         end
         WR_RESP: begin
            bready = 1'b1;
            if (bus.io_master_bvalid) state_nx = RESP;
         end
         RESP: begin
            ifu_resp = (owner == OWN_IFU);
            lsu_resp = (owner == OWN_LSU);
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // Latch the accepted request and collect handshake/response results.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         owner   <= OWN_IFU;
         addr_q  <= '0;
         size_q  <= '0;
         sh_q    <= '0;
         wdata_q <= '0;
         wstrb_q <= '0;
         aw_done <= 1'b0;
         w_done  <= 1'b0;
         data_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         if (grant_lsu) begin
            owner   <= OWN_LSU;
            addr_q  <= bus.lsu_addr;
            size_q  <= bus.lsu_size;
            sh_q    <= bus.lsu_addr[1:0];
            wdata_q <= bus.lsu_wdata << {bus.lsu_addr[1:0], 3'b000};
            wstrb_q <= bus.lsu_wstrb << bus.lsu_addr[1:0];
         end else if (grant_ifu) begin
            owner   <= OWN_IFU;
            addr_q  <= bus.ifu_addr;
            size_q  <= 3'd2;
            sh_q    <= 2'd0;
            wdata_q <= '0;
            wstrb_q <= '0;
         end
         if (state == IDLE) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
         end
         if (awvalid && bus.io_master_awready) aw_done <= 1'b1;
         if (wvalid && bus.io_master_wready)   w_done  <= 1'b1;
         if (rready && bus.io_master_rvalid) begin
            data_q <= bus.io_master_rdata >> {sh_q, 3'b000};
            err_q  <= bus.io_master_rresp[1];
         end
         if (bready && bus.io_master_bvalid) begin
            data_q <= '0;
            err_q  <= bus.io_master_bresp[1];
         end
      end
   end

   assign bus.ifu_req_ready  = grant_ifu;
   assign bus.lsu_req_ready  = grant_lsu;
   assign bus.ifu_resp_valid = ifu_resp;
   assign bus.lsu_resp_valid = lsu_resp;
   assign bus.ifu_rdata      = data_q;
   assign bus.lsu_rdata      = data_q;
   assign bus.ifu_resp_err   = err_q;
   assign bus.lsu_resp_err   = err_q;

   assign bus.io_master_awvalid = awvalid;
   assign bus.io_master_awaddr  = addr_q;
   assign bus.io_master_awsize  = size_q;
   assign bus.io_master_awid    = 4'd0;
   assign bus.io_master_awlen   = 8'd0;
   assign bus.io_master_awburst = 2'b01;
   assign bus.io_master_wvalid  = wvalid;
   assign bus.io_master_wdata   = wdata_q;
   assign bus.io_master_wstrb   = wstrb_q;
   assign bus.io_master_wlast   = 1'b1;
   assign bus.io_master_bready  = bready;
   assign bus.io_master_arvalid = arvalid;
   assign bus.io_master_araddr  = addr_q;
   assign bus.io_master_arsize  = size_q;
   assign bus.io_master_arid    = 4'd0;
   assign bus.io_master_arlen   = 8'd0;
   assign bus.io_master_arburst = 2'b01;
   assign bus.io_master_rready  = rready;

endmodule

// File: tb/tb_axi_master_arbiter.sv
// Scoreboard bench for axi_master_arbiter with a small AXI slave model.
// Honours YSYX_ARB_RR_EN when predicting grant order.
module tb_axi_master_arbiter;

   logic clock = 1'b0;
   logic reset = 1'b1;

   axi_master_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   axi_master_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   typedef struct {
      bit          lsu;
      logic [31:0] data;
      bit          chk_data;
      bit          err;
      int          lat;
   } exp_t;

   exp_t sb[$];

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;
   int acc_cyc = 0;
   int ar_cyc = 0;
   int aw_cyc = 0;
   int w_cyc = 0;
   int resp_cnt = 0;
   bit tb_last_lsu = 1'b0;

   // slave configuration
   int          ar_lat = 0;
   int          aw_lat = 0;
   int          w_lat = 0;
   logic [31:0] rd_val = '0;
   logic [1:0]  r_resp = '0;
   logic [1:0]  b_resp = '0;
   bit          r_hold = 1'b0;

   // slave state and captured request fields
   int          ar_cnt, aw_cnt, w_cnt;
   logic        s_rvalid, s_bvalid, aw_seen, w_seen;
   logic [31:0] s_araddr, s_awaddr, s_wdata;
   logic [2:0]  s_arsize, s_awsize;
   logic [3:0]  s_wstrb;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   assign bus.io_master_arready = bus.io_master_arvalid && (ar_cnt >= ar_lat);
   assign bus.io_master_awready = bus.io_master_awvalid && (aw_cnt >= aw_lat);
   assign bus.io_master_wready  = bus.io_master_wvalid && (w_cnt >= w_lat);
   assign bus.io_master_rvalid  = s_rvalid;
   assign bus.io_master_rdata   = s_rvalid ? rd_val : 32'h0;
   assign bus.io_master_rresp   = s_rvalid ? r_resp : 2'b00;
   assign bus.io_master_rlast   = s_rvalid;
   assign bus.io_master_rid     = 4'd0;
   assign bus.io_master_bvalid  = s_bvalid;
   assign bus.io_master_bresp   = s_bvalid ? b_resp : 2'b00;
   assign bus.io_master_bid     = 4'd0;

   always @(posedge clock) cyc <= cyc + 1;

   // AXI slave: read data one cycle after AR, write resp one cycle after AW+W.
   always @(posedge clock or posedge reset) begin
      if (reset) begin
         ar_cnt <= 0; aw_cnt <= 0; w_cnt <= 0;
         s_rvalid <= 1'b0; s_bvalid <= 1'b0;
         aw_seen <= 1'b0; w_seen <= 1'b0;
      end else begin
         ar_cnt <= (bus.io_master_arvalid && !bus.io_master_arready) ? ar_cnt + 1 : 0;
         aw_cnt <= (bus.io_master_awvalid && !bus.io_master_awready) ? aw_cnt + 1 : 0;
         w_cnt  <= (bus.io_master_wvalid && !bus.io_master_wready) ? w_cnt + 1 : 0;
         if (s_rvalid && bus.io_master_rready) s_rvalid <= 1'b0;
         if (bus.io_master_arvalid && bus.io_master_arready) begin
            s_rvalid <= !r_hold;
            s_araddr <= bus.io_master_araddr;
            s_arsize <= bus.io_master_arsize;
         end
         if (s_bvalid && bus.io_master_bready) s_bvalid <= 1'b0;
         if (bus.io_master_awvalid && bus.io_master_awready) begin
            aw_seen  <= 1'b1;
            s_awaddr <= bus.io_master_awaddr;
            s_awsize <= bus.io_master_awsize;
         end
         if (bus.io_master_wvalid && bus.io_master_wready) begin
            w_seen  <= 1'b1;
            s_wdata <= bus.io_master_wdata;
            s_wstrb <= bus.io_master_wstrb;
         end
         if ((aw_seen || (bus.io_master_awvalid && bus.io_master_awready)) &&
             (w_seen || (bus.io_master_wvalid && bus.io_master_wready))) begin
            s_bvalid <= 1'b1;
            aw_seen  <= 1'b0;
            w_seen   <= 1'b0;
         end
      end
   end

   // Monitor: timestamp handshakes and score every response pulse.
   always @(negedge clock) begin
      if ((bus.ifu_req_valid && bus.ifu_req_ready) ||
          (bus.lsu_req_valid && bus.lsu_req_ready))
         acc_cyc = cyc;
      if (bus.io_master_arvalid && bus.io_master_arready) ar_cyc = cyc;
      if (bus.io_master_awvalid && bus.io_master_awready) aw_cyc = cyc;
      if (bus.io_master_wvalid && bus.io_master_wready)   w_cyc = cyc;
      if (bus.ifu_resp_valid || bus.lsu_resp_valid) begin
         exp_t e;
         resp_cnt++;
         check("resp_onehot", {31'd0, bus.ifu_resp_valid & bus.lsu_resp_valid}, 0);
         if (sb.size() == 0) begin
            check("resp_extra", 1, 0);
         end else begin
            e = sb.pop_front();
            check("resp_owner", {31'd0, bus.lsu_resp_valid}, {31'd0, e.lsu});
            if (e.lsu) begin
               if (e.chk_data) check("lsu_rdata", bus.lsu_rdata, e.data);
               check("lsu_err", {31'd0, bus.lsu_resp_err}, {31'd0, e.err});
            end else begin
               if (e.chk_data) check("ifu_rdata", bus.ifu_rdata, e.data);
               check("ifu_err", {31'd0, bus.ifu_resp_err}, {31'd0, e.err});
            end
            if (e.lat >= 0) check("resp_lat", cyc - acc_cyc, e.lat);
         end
      end
   end

   function automatic exp_t mk(input bit lsu, input logic [31:0] d,
                               input bit cd, input bit err, input int lat);
      exp_t e;
      e.lsu = lsu; e.data = d; e.chk_data = cd; e.err = err; e.lat = lat;
      return e;
   endfunction

   task automatic ifu_go(input logic [31:0] a);
      bit acc;
      acc = 1'b0;
      @(posedge clock); #1;
      bus.ifu_req_valid = 1'b1;
      bus.ifu_addr = a;
      for (int n = 0; n < 50 && !acc; n++) begin
         @(negedge clock);
         acc = bus.ifu_req_ready;
      end
      if (!acc) check("ifu_accept_timeout", 0, 1);
      @(posedge clock); #1;
      bus.ifu_req_valid = 1'b0;
      tb_last_lsu = 1'b0;
   endtask

   task automatic lsu_go(input logic wen, input logic [31:0] a,
                         input logic [2:0] sz, input logic [31:0] wd,
                         input logic [3:0] ws);
      bit acc;
      acc = 1'b0;
      @(posedge clock); #1;
      bus.lsu_req_valid = 1'b1;
      bus.lsu_wen = wen;
      bus.lsu_addr = a;
      bus.lsu_size = sz;
      bus.lsu_wdata = wd;
      bus.lsu_wstrb = ws;
      for (int n = 0; n < 50 && !acc; n++) begin
         @(negedge clock);
         acc = bus.lsu_req_ready;
      end
      if (!acc) check("lsu_accept_timeout", 0, 1);
      @(posedge clock); #1;
      bus.lsu_req_valid = 1'b0;
      tb_last_lsu = 1'b1;
   endtask

   task automatic drain();
      for (int n = 0; n < 100 && sb.size() != 0; n++) @(negedge clock);
      if (sb.size() != 0) begin
         check("drain_timeout", sb.size(), 0);
         sb.delete();
      end
      @(posedge clock);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit l_done, i_done, l_acc, i_acc, ifu_first, got;
      int r0;

      bus.ifu_req_valid = 1'b1;
      bus.ifu_addr = 32'h8000_0000;
      bus.lsu_req_valid = 1'b1;
      bus.lsu_wen = 1'b0;
      bus.lsu_addr = '0;
      bus.lsu_size = '0;
      bus.lsu_wdata = '0;
      bus.lsu_wstrb = '0;

      // reset values with both requesters valid
      repeat (3) @(negedge clock);
      check("rst_ifu_ready", {31'd0, bus.ifu_req_ready}, 0);
      check("rst_lsu_ready", {31'd0, bus.lsu_req_ready}, 0);
      check("rst_arvalid", {31'd0, bus.io_master_arvalid}, 0);
      check("rst_awvalid", {31'd0, bus.io_master_awvalid}, 0);
      check("rst_rdata", bus.ifu_rdata, 0);
      check("const_burst", {30'd0, bus.io_master_awburst}, 1);
      check("const_wlast", {31'd0, bus.io_master_wlast}, 1);
      check("const_arlen", {24'd0, bus.io_master_arlen}, 0);
      bus.ifu_req_valid = 1'b0;
      bus.lsu_req_valid = 1'b0;
      reset = 1'b0;

      // IFU zero-wait read
      rd_val = 32'h0010_0093;
      sb.push_back(mk(0, 32'h0010_0093, 1, 0, 3));
      ifu_go(32'h8000_0000);
      drain();
      check("ar_lat", ar_cyc - acc_cyc, 1);
      check("ifu_araddr", s_araddr, 32'h8000_0000);
      check("ifu_arsize", {29'd0, s_arsize}, 2);

      // LSU byte store at offset 3, W two cycles ahead of AW
      aw_lat = 2;
      sb.push_back(mk(1, 0, 0, 0, -1));
      lsu_go(1, 32'h8000_1003, 3'd0, 32'h0000_00AB, 4'b0001);
      drain();
      aw_lat = 0;
      check("sb_wstrb", {28'd0, s_wstrb}, 32'h8);
      check("sb_wdata", s_wdata, 32'hAB00_0000);
      check("sb_awsize", {29'd0, s_awsize}, 0);
      check("sb_awaddr", s_awaddr, 32'h8000_1003);
      check("sb_w_before_aw", aw_cyc - w_cyc, 2);

      // LSU zero-wait word store
      sb.push_back(mk(1, 0, 0, 0, 4));
      lsu_go(1, 32'h8000_2000, 3'd2, 32'h1234_5678, 4'b1111);
      drain();
      check("sw_wdata", s_wdata, 32'h1234_5678);
      check("sw_wstrb", {28'd0, s_wstrb}, 32'hF);

      // LSU halfword load from offset 2
      rd_val = 32'hBEEF_1234;
      sb.push_back(mk(1, 32'h0000_BEEF, 1, 0, 3));
      lsu_go(0, 32'h8000_1002, 3'd1, 32'h0, 4'b0000);
      drain();
      check("lhu_arsize", {29'd0, s_arsize}, 1);

      // IFU and LSU in the same idle cycle
      rd_val = 32'hCAFE_F00D;
`ifdef YSYX_ARB_RR_EN
      ifu_first = tb_last_lsu;
`else
      ifu_first = 1'b0;
`endif
      if (ifu_first) begin
         sb.push_back(mk(0, 32'hCAFE_F00D, 1, 0, 3));
         sb.push_back(mk(1, 32'hCAFE_F00D, 1, 0, 3));
      end else begin
         sb.push_back(mk(1, 32'hCAFE_F00D, 1, 0, 3));
         sb.push_back(mk(0, 32'hCAFE_F00D, 1, 0, 3));
      end
      @(posedge clock); #1;
      bus.ifu_req_valid = 1'b1;
      bus.ifu_addr = 32'h8000_0010;
      bus.lsu_req_valid = 1'b1;
      bus.lsu_wen = 1'b0;
      bus.lsu_addr = 32'h8000_3000;
      bus.lsu_size = 3'd2;
      l_done = 1'b0;
      i_done = 1'b0;
      for (int n = 0; n < 60 && !(l_done && i_done); n++) begin
         @(negedge clock);
         l_acc = bus.lsu_req_ready;
         i_acc = bus.ifu_req_ready;
         @(posedge clock); #1;
         if (l_acc) begin bus.lsu_req_valid = 1'b0; l_done = 1'b1; end
         if (i_acc) begin bus.ifu_req_valid = 1'b0; i_done = 1'b1; end
      end
      check("both_accepted", {30'd0, l_done, i_done}, 3);
      bus.ifu_req_valid = 1'b0;
      bus.lsu_req_valid = 1'b0;
      tb_last_lsu = !ifu_first;
      drain();

      // read error, then a clean read
      rd_val = 32'h1111_2222;
      r_resp = 2'b10;
      sb.push_back(mk(0, 32'h1111_2222, 1, 1, 3));
      ifu_go(32'h8000_0020);
      drain();
      r_resp = 2'b00;
      rd_val = 32'h3333_4444;
      sb.push_back(mk(0, 32'h3333_4444, 1, 0, 3));
      ifu_go(32'h8000_0024);
      drain();

      // write error with a slow AR-free path and W stalled
      b_resp = 2'b10;
      w_lat = 1;
      sb.push_back(mk(1, 0, 0, 1, -1));
      lsu_go(1, 32'h8000_4001, 3'd1, 32'h0000_5A5A, 4'b0011);
      drain();
      b_resp = 2'b00;
      w_lat = 0;
      check("sh_wstrb", {28'd0, s_wstrb}, 32'h6);
      check("sh_wdata", s_wdata, 32'h005A_5A00);

      // reset while waiting in RD_DATA
      r_hold = 1'b1;
      r0 = resp_cnt;
      ifu_go(32'h8000_0100);
      got = 1'b0;
      for (int n = 0; n < 20 && !got; n++) begin
         @(negedge clock);
         got = bus.io_master_rready;
      end
      check("rd_data_reached", {31'd0, got}, 1);
      bus.ifu_req_valid = 1'b1;
      bus.ifu_addr = 32'h8000_0200;
      #1;
      check("busy_ready", {31'd0, bus.ifu_req_ready}, 0);
      #1;
      reset = 1'b1;
      #1;
      check("rst_mid_arvalid", {31'd0, bus.io_master_arvalid}, 0);
      check("rst_mid_rready", {31'd0, bus.io_master_rready}, 0);
      check("rst_mid_ready", {31'd0, bus.ifu_req_ready}, 0);
      bus.ifu_req_valid = 1'b0;
      r_hold = 1'b0;
      repeat (3) @(negedge clock);
      reset = 1'b0;
      repeat (3) @(negedge clock);
      check("rst_no_resp", resp_cnt, r0);

      // fresh read after reset
      rd_val = 32'h0000_0513;
      sb.push_back(mk(0, 32'h0000_0513, 1, 0, 3));
      ifu_go(32'h8000_0000);
      drain();
      check("post_rst_araddr", s_araddr, 32'h8000_0000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
